pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the five-stage LEGv8 pipeline. It sits beside the operand-forwarding unit and covers the hazards forwarding cannot resolve:
- load-use hazards, by inserting one bubble;
- taken branches resolved in MEM, by flushing the younger stages;
- data-memory wait states, by freezing the whole pipeline until dmem_ready or a timeout.
It also keeps stall and flush performance counters.

Parameters:
MEM_TIMEOUT, 16, max consecutive wait cycles before mem_error is raised (≥2)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high reset
IFID_RegisterRn  in  5  source register Rn of the instruction in ID
IFID_RegisterRm  in  5  source register Rm (or Rt for stores) of the instruction in ID
IDEX_RegisterRd  in  5  destination register of the instruction in EX
IDEX_MemRead  in  1  instruction in EX is a load
EXMEM_MemAccess  in  1  instruction in MEM is a load or store
EXMEM_BranchTaken  in  1  branch in MEM resolved taken
dmem_ready  in  1  data memory completes the access this cycle
PCWrite  out  1  PC update enable
IFID_Write  out  1  IF/ID register enable
IDEX_Write  out  1  ID/EX register enable
EXMEM_Write  out  1  EX/MEM register enable
IDEX_Bubble  out  1  zero the control signals entering ID/EX
IFID_Flush  out  1  clear IF/ID
IDEX_Flush  out  1  clear ID/EX
EXMEM_Flush  out  1  clear EX/MEM control signals
MEMWB_Bubble  out  1  zero the control signals entering MEM/WB
mem_error  out  1  sticky memory-timeout flag
stall_cycles  out  CNT_W  count of cycles with PCWrite=0
flush_count  out  CNT_W  count of taken-branch flushes

Behaviour:
- Control outputs are combinational (Mealy) from state and inputs. Counters, wait counter, state and mem_error are registered.
- Reset (asynchronous):
  - state=RUN, wait_cnt=0, mem_error=0, stall_cycles=0, flush_count=0.
  - While reset is held, all enables are 1 and all flush/bubble outputs are 0.
- States: RUN, MEM_WAIT, ERROR (2-bit encoding).
- Load-use condition (lu): IDEX_MemRead && IDEX_RegisterRd!=31 && (IDEX_RegisterRd==IFID_RegisterRn || IDEX_RegisterRd==IFID_RegisterRm). XZR (register 31) never causes a hazard.
- Memory-wait condition (mw): EXMEM_MemAccess && !dmem_ready.
- RUN, priority mw > branch > lu:
  - mw: PCWrite=IFID_Write=IDEX_Write=EXMEM_Write=0, MEMWB_Bubble=1. Next state MEM_WAIT, wait_cnt=1.
  - EXMEM_BranchTaken: IFID_Flush=IDEX_Flush=EXMEM_Flush=1, all enables 1, flush_count+1. A simultaneous lu is ignored because the dependent instruction is flushed.
  - lu: PCWrite=0, IFID_Write=0, IDEX_Bubble=1. Stall lasts exactly 1 cycle; stays in RUN.
  - Otherwise all enables 1, all flush/bubble outputs 0.
- MEM_WAIT:
  - Freeze as above while !dmem_ready; wait_cnt increments.
  - Branch and lu are not evaluated; EX/MEM is frozen, so any branch is evaluated once the wait ends.
  - dmem_ready=1: behave exactly as RUN with mw=0 in the same cycle (branch/lu evaluated). Next state RUN, wait_cnt=0.
  - If wait_cnt==MEM_TIMEOUT and still !dmem_ready: next state ERROR, mem_error=1.
- ERROR: pipeline stays frozen (mw outputs) until reset. mem_error holds 1.
- stall_cycles increments on every cycle with PCWrite=0 outside reset. Both counters saturate at all-ones; they do not wrap.
- Reset mid-wait: immediately RUN, freeze released, counters cleared.

Decomposition:
- Shared package hazard_pkg:
  - state encoding (ST_RUN=0, ST_MEM_WAIT=1, ST_ERROR=2);
  - constant XZR=5'd31;
  - function for the load-use compare. The forwarding unit reuses the XZR constant.
- One natural sub-module: sat_counter (CNT_W, inc, clear), instantiated twice for the performance counters.

Test Plan:
- Load X2 in EX (IDEX_RegisterRd=2, IDEX_MemRead=1), IFID_RegisterRm=2 -> one cycle of PCWrite=0, IFID_Write=0, IDEX_Bubble=1; next cycle with IDEX_MemRead=0 -> all enables 1; stall_cycles=1.
- Same as above with IDEX_RegisterRd=31 -> no stall, stall_cycles=0.
- EXMEM_BranchTaken=1 together with a load-use condition -> IFID_Flush=IDEX_Flush=EXMEM_Flush=1, PCWrite=1, IDEX_Bubble=0, flush_count=1.
- EXMEM_MemAccess=1, dmem_ready low 3 cycles then high -> 3 frozen cycles (all enables 0, MEMWB_Bubble=1), 4th cycle normal, state RUN, stall_cycles=3.
- MEM_TIMEOUT=4, dmem_ready held low -> mem_error=1 after the 4th wait cycle and pipeline stays frozen; assert reset asynchronously mid-cycle -> outputs return to reset values immediately, mem_error=0.
- Branch pending in MEM during a 2-cycle memory wait -> no flush while frozen; flush asserted in the dmem_ready cycle, flush_count=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the LEGv8 hazard controller and its neighbours
// (the forwarding unit reuses XZR).
package hazard_pkg;

   // Sequencer states, 2-bit encoding
   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERROR    = 2'd2
   } hazState_t;

   // Zero register: never written, so never the source of a hazard
   localparam logic [4:0] XZR = 5'd31;

   // Load in EX whose destination feeds either source of the instruction in ID
   function automatic logic loadUseHazard(
      input logic       memRead,
      input logic [4:0] rd,
      input logic [4:0] rn,
      input logic [4:0] rm
   );
      return memRead && (rd != XZR) && ((rd == rn) || (rd == rm));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clear,
   output logic [CNT_W-1:0] count
);

   // Count up on inc, stick at all-ones instead of wrapping
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the five-stage LEGv8 pipeline: load-use bubbles,
// taken-branch flushes, and whole-pipeline freeze on data-memory wait states.
module pipeline_hazard_controller
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       IFID_RegisterRn,
   input  logic [4:0]       IFID_RegisterRm,
   input  logic [4:0]       IDEX_RegisterRd,
   input  logic             IDEX_MemRead,
   input  logic             EXMEM_MemAccess,
   input  logic             EXMEM_BranchTaken,
   input  logic             dmem_ready,
   output logic             PCWrite,
   output logic             IFID_Write,
   output logic             IDEX_Write,
   output logic             EXMEM_Write,
   output logic             IDEX_Bubble,
   output logic             IFID_Flush,
   output logic             IDEX_Flush,
   output logic             EXMEM_Flush,
   output logic             MEMWB_Bubble,
   output logic             mem_error,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   hazState_t         stateReg, stateNext;
   logic [WAIT_W-1:0] waitCntReg, waitCntNext;
   logic              memErrorReg, memErrorNext;

   logic loadUse;
   logic memWait;
   logic freeze;
   logic evalRun;
   logic branchFlush;
   logic luStall;

   assign loadUse = loadUseHazard(IDEX_MemRead, IDEX_RegisterRd,
                                  IFID_RegisterRn, IFID_RegisterRm);
   assign memWait = EXMEM_MemAccess && !dmem_ready;

   // State, wait counter and sticky error flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stateReg    <= ST_RUN;
         waitCntReg  <= '0;
         memErrorReg <= 1'b0;
      end else begin
         stateReg    <= stateNext;
         waitCntReg  <= waitCntNext;
         memErrorReg <= memErrorNext;
      end
   end

   // Next state: enter wait on a stalled access, leave on ready, give up on timeout.
   // The timeout compares the count this cycle would produce, so the error is
   // flagged after exactly MEM_TIMEOUT frozen cycles.
   always_comb begin
      stateNext    = stateReg;
      waitCntNext  = waitCntReg;
      memErrorNext = memErrorReg;
      case (stateReg)
         ST_RUN: begin
            if (memWait) begin
               stateNext   = ST_MEM_WAIT;
               waitCntNext = WAIT_W'(1);
            end
         end
         ST_MEM_WAIT: begin
            if (dmem_ready) begin
               stateNext   = ST_RUN;
               waitCntNext = '0;
            end else if (waitCntReg == WAIT_W'(MEM_TIMEOUT - 1)) begin
               stateNext    = ST_ERROR;
               waitCntNext  = WAIT_W'(MEM_TIMEOUT);
               memErrorNext = 1'b1;
            end else begin
               waitCntNext = waitCntReg + WAIT_W'(1);
            end
         end
         ST_ERROR: begin
            memErrorNext = 1'b1;
         end
         default: begin
            stateNext   = ST_RUN;
            waitCntNext = '0;
         end
      endcase
   end

   // Mealy control outputs; memory freeze beats branch flush beats load-use bubble.
   // While reset is held the pipeline runs free with no flushes or bubbles.
   always_comb begin
      freeze  = 1'b0;
      evalRun = 1'b0;
      case (stateReg)
         ST_RUN: begin
            freeze  = memWait;
            evalRun = !memWait;
         end
         ST_MEM_WAIT: begin
            // EX/MEM held still, so a pending branch is only acted on once ready
            freeze  = !dmem_ready;
            evalRun = dmem_ready;
         end
         ST_ERROR: begin
            freeze = 1'b1;
         end
         default: begin
            evalRun = 1'b1;
         end
      endcase

      if (reset) begin
         freeze  = 1'b0;
         evalRun = 1'b0;
      end

      branchFlush = evalRun && EXMEM_BranchTaken;
      // A dependent instruction that is being flushed needs no bubble
      luStall     = evalRun && !EXMEM_BranchTaken && loadUse;

      PCWrite      = !(freeze || luStall);
      IFID_Write   = !(freeze || luStall);
      IDEX_Write   = !freeze;
      EXMEM_Write  = !freeze;
      IDEX_Bubble  = luStall;
      IFID_Flush   = branchFlush;
      IDEX_Flush   = branchFlush;
      EXMEM_Flush  = branchFlush;
      MEMWB_Bubble = freeze;
   end

   assign mem_error = memErrorReg;

   sat_counter #(.CNT_W(CNT_W)) stallCounter (
      .clk   (clk),
      .reset (reset),
      .inc   (!PCWrite),
      .clear (1'b0),
      .count (stall_cycles)
   );

   sat_counter #(.CNT_W(CNT_W)) flushCounter (
      .clk   (clk),
      .reset (reset),
      .inc   (IFID_Flush),
      .clear (1'b0),
      .count (flush_count)
   );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed and random checks of the hazard controller against a cycle-level
// behavioural model of the stall/flush rules.
module tb_pipeline_hazard_controller;

   localparam int TMO  = 4;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   // {PCWrite,IFID_Write,IDEX_Write,EXMEM_Write,IDEX_Bubble,IFID_Flush,IDEX_Flush,EXMEM_Flush,MEMWB_Bubble}
   localparam logic [8:0] C_NORMAL = 9'b1111_0000_0;
   localparam logic [8:0] C_FROZEN = 9'b0000_0000_1;
   localparam logic [8:0] C_BRANCH = 9'b1111_0111_0;
   localparam logic [8:0] C_LU     = 9'b0011_1000_0;

   logic          clk = 1'b0;
   logic          reset;
   logic [4:0]    rn, rm, rd;
   logic          memRead, memAccess, branch, ready;
   logic          pcW, ifidW, idexW, exmemW, idexB, ifidF, idexF, exmemF, memwbB;
   logic          memErr;
   logic [CW-1:0] stallCnt, flushCnt;
   logic [8:0]    ctl;

   int total = 0;
   int bad   = 0;

   // Model state
   int frozenRun;
   bit mErr;
   int mStall;
   int mFlush;

   pipeline_hazard_controller #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk               (clk),
      .reset             (reset),
      .IFID_RegisterRn   (rn),
      .IFID_RegisterRm   (rm),
      .IDEX_RegisterRd   (rd),
      .IDEX_MemRead      (memRead),
      .EXMEM_MemAccess   (memAccess),
      .EXMEM_BranchTaken (branch),
      .dmem_ready        (ready),
      .PCWrite           (pcW),
      .IFID_Write        (ifidW),
      .IDEX_Write        (idexW),
      .EXMEM_Write       (exmemW),
      .IDEX_Bubble       (idexB),
      .IFID_Flush        (ifidF),
      .IDEX_Flush        (idexF),
      .EXMEM_Flush       (exmemF),
      .MEMWB_Bubble      (memwbB),
      .mem_error         (memErr),
      .stall_cycles      (stallCnt),
      .flush_count       (flushCnt)
   );

   assign ctl = {pcW, ifidW, idexW, exmemW, idexB, ifidF, idexF, exmemF, memwbB};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      frozenRun = 0;
      mErr      = 1'b0;
      mStall    = 0;
      mFlush    = 0;
   endtask

   // Expected control vector for the current inputs and model history
   function automatic logic [8:0] modelCtl();
      bit lu;
      bit waiting;
      lu      = memRead && (rd != 5'd31) && (rd == rn || rd == rm);
      waiting = frozenRun > 0;
      if (reset)                                      return C_NORMAL;
      if (mErr || (!ready && (waiting || memAccess))) return C_FROZEN;
      if (branch)                                     return C_BRANCH;
      if (lu)                                         return C_LU;
      return C_NORMAL;
   endfunction

   // Advance the model across one clock edge given the cycle's controls
   task automatic modelEdge(input logic [8:0] c);
      if (reset) return;
      if (!c[8] && mStall < CMAX) mStall++;
      if (c[3] && mFlush < CMAX)  mFlush++;
      if (c == C_FROZEN) begin
         if (!mErr) begin
            frozenRun++;
            if (frozenRun == TMO) mErr = 1'b1;
         end
      end else begin
         frozenRun = 0;
      end
   endtask

   // One clock cycle: drive, check combinational outputs, clock, check registers
   task automatic step(input string tag, input logic [4:0] iRn, input logic [4:0] iRm,
                       input logic [4:0] iRd, input logic iMemRead, input logic iMemAccess,
                       input logic iBranch, input logic iReady);
      logic [8:0] exp;
      rn = iRn; rm = iRm; rd = iRd;
      memRead = iMemRead; memAccess = iMemAccess; branch = iBranch; ready = iReady;
      #3;
      exp = modelCtl();
      chk({tag, "_ctl"}, 32'(ctl), 32'(exp));
      @(posedge clk);
      modelEdge(exp);
      #1;
      chk({tag, "_err"},   32'(memErr),   32'(mErr));
      chk({tag, "_stall"}, 32'(stallCnt), 32'(mStall));
      chk({tag, "_flush"}, 32'(flushCnt), 32'(mFlush));
      $display("step %s ctl=%b err=%b stall=%0d flush=%0d", tag, ctl, memErr, stallCnt, flushCnt);
   endtask

   task automatic doReset();
      reset = 1'b1;
      modelReset();
      @(posedge clk);
      #1;
      chk("rst_ctl",   32'(ctl),      32'(C_NORMAL));
      chk("rst_err",   32'(memErr),   32'd0);
      chk("rst_stall", 32'(stallCnt), 32'd0);
      chk("rst_flush", 32'(flushCnt), 32'd0);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; rn = '0; rm = '0; rd = '0;
      memRead = 1'b0; memAccess = 1'b0; branch = 1'b0; ready = 1'b1;
      modelReset();
      @(posedge clk);
      #1;

      // Load-use on Rm: one bubble, then free running
      doReset();
      step("lu", 5'd5, 5'd2, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("lu_stallctl", 32'(ctl), 32'(C_LU));
      step("lu_after", 5'd5, 5'd2, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("lu_cnt", 32'(stallCnt), 32'd1);

      // Load into XZR never stalls
      doReset();
      step("xzr", 5'd31, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("xzr_cnt", 32'(stallCnt), 32'd0);

      // Taken branch overrides a simultaneous load-use
      doReset();
      step("br_lu", 5'd3, 5'd7, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("br_lu_cnt", 32'(flushCnt), 32'd1);

      // Three wait cycles then ready
      doReset();
      for (int i = 0; i < 3; i++) step("mw", 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("mw_frozen", 32'(ctl), 32'(C_FROZEN));
      step("mw_ready", 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("mw_readyctl", 32'(ctl), 32'(C_NORMAL));
      chk("mw_cnt", 32'(stallCnt), 32'd3);

      // Timeout into the error state, then asynchronous reset mid-cycle
      doReset();
      for (int i = 0; i < 6; i++) step("tmo", 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("tmo_err", 32'(memErr), 32'd1);
      ready = 1'b1;
      #2;
      chk("err_hold_ctl", 32'(ctl), 32'(C_FROZEN));
      reset = 1'b1;
      #1;
      chk("arst_ctl",   32'(ctl),      32'(C_NORMAL));
      chk("arst_err",   32'(memErr),   32'd0);
      chk("arst_stall", 32'(stallCnt), 32'd0);
      modelReset();
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Branch held in MEM across a two-cycle wait
      doReset();
      for (int i = 0; i < 2; i++) step("brw", 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("brw_noflush", 32'(flushCnt), 32'd0);
      step("brw_ready", 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("brw_cnt", 32'(flushCnt), 32'd1);

      // Counters saturate at all-ones
      doReset();
      for (int i = 0; i < CMAX + 2; i++) step("sat_lu", 5'd4, 5'd1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("sat_stall", 32'(stallCnt), 32'(CMAX));
      for (int i = 0; i < CMAX + 2; i++) step("sat_br", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("sat_flush", 32'(flushCnt), 32'(CMAX));

      // Random traffic; recover from the error state by resetting
      doReset();
      begin
         int errCycles = 0;
         for (int i = 0; i < 200; i++) begin
            logic [4:0] r0, r1, r2;
            int t;
            t  = $urandom_range(0, 4); r0 = (t == 4) ? 5'd31 : 5'(t);
            t  = $urandom_range(0, 4); r1 = (t == 4) ? 5'd31 : 5'(t);
            t  = $urandom_range(0, 4); r2 = (t == 4) ? 5'd31 : 5'(t);
            step("rnd", r0, r1, r2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 65));
            if (mErr) errCycles++;
            if (errCycles > 3) begin
               errCycles = 0;
               doReset();
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
